// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encoding and constants for the instruction/data bus arbiter.
// Purpose: types only. Latency: none. Backpressure: none.
package arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_DATA,
    ARB_INSTR,
    ARB_DRAIN,
    ARB_RESP
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: memory ack watchdog; expired is high in the LIMIT-th cycle after start.
// Latency: expired is combinational from the count. Backpressure: none, clear wins over start.
module bus_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt_q;
  logic        run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Count 0 is the first strobe cycle, so LIMIT-1 marks the LIMIT-th strobe cycle.
  assign expired = run_q && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: merges instruction and data buses onto one single-port memory bus, data first; BUS_TIMEOUT_EN adds an ack watchdog.
// Latency: request -> registered strobe next cycle; ack -> one-cycle response pulse next cycle.
// Backpressure: one transaction outstanding; requesters hold their level until their response pulse.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_NOP    = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_flush_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rsp_o,
  output logic [31:0] instr_data_o,
  input  logic        data_rd_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rsp_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        bus_error_o
);

  arb_state_t  state_q, state_d;
  logic        op_wr_q, rsp_data_q, err_q;
  logic [31:0] addr_q, wdata_q, drdata_q, irdata_q;
  logic        data_req, grant_data, grant_instr, active, done, tmo;

  assign data_req    = data_rd_i | data_wr_i;
  assign grant_data  = (state_q == ARB_IDLE) && data_req;
  assign grant_instr = (state_q == ARB_IDLE) && !data_req && instr_req_i && !instr_flush_i;
  assign active      = (state_q == ARB_DATA) || (state_q == ARB_INSTR) || (state_q == ARB_DRAIN);
  assign done        = mem_ack_i | tmo;

`ifdef BUS_TIMEOUT_EN
  bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (grant_data | grant_instr),
    .clear   (active & done),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (data_req)                           state_d = ARB_DATA;
        else if (instr_req_i && !instr_flush_i) state_d = ARB_INSTR;
      end
      ARB_DATA: if (done) state_d = ARB_RESP;
      ARB_INSTR: begin
        // A flush overrides completion: the word is dropped whether acked or timed out.
        if (instr_flush_i) state_d = done ? ARB_IDLE : ARB_DRAIN;
        else if (done)     state_d = ARB_RESP;
      end
      ARB_DRAIN: if (done) state_d = ARB_IDLE;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q    <= 1'b0;
      rsp_data_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      drdata_q   <= '0;
      irdata_q   <= '0;
    end else begin
      err_q <= active && tmo && !mem_ack_i;
      if (grant_data) begin
        op_wr_q <= data_wr_i;
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
      end else if (grant_instr) begin
        op_wr_q <= 1'b0;
        addr_q  <= instr_addr_i;
      end
      if ((state_q == ARB_DATA) && done) begin
        rsp_data_q <= 1'b1;
        drdata_q   <= mem_ack_i ? mem_rdata_i : 32'h0;
      end
      if ((state_q == ARB_INSTR) && done) begin
        rsp_data_q <= 1'b0;
        irdata_q   <= mem_ack_i ? mem_rdata_i : TIMEOUT_NOP;
      end
    end
  end

  // Strobes decode straight from the state register, so they stay glitch-free and registered.
  always_comb begin
    mem_rd_o     = ((state_q == ARB_DATA) && !op_wr_q) || (state_q == ARB_INSTR) ||
                   (state_q == ARB_DRAIN);
    mem_wr_o     = (state_q == ARB_DATA) && op_wr_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    data_rsp_o   = (state_q == ARB_RESP) && rsp_data_q;
    instr_rsp_o  = (state_q == ARB_RESP) && !rsp_data_q;
    data_rdata_o = drdata_q;
    instr_data_o = irdata_q;
    bus_error_o  = err_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; responses are checked against a queue of expected results.
module tb_mem_bus_arbiter;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_flush_i = 1'b0, instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_rsp_o;
  logic [31:0] instr_data_o;
  logic        data_rd_i = 1'b0, data_wr_i = 1'b0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_rsp_o;
  logic [31:0] data_rdata_o;
  logic        mem_rd_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        bus_error_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_NOP(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_flush_i(instr_flush_i), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_rsp_o(instr_rsp_o), .instr_data_o(instr_data_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rsp_o(data_rsp_o), .data_rdata_o(data_rdata_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic is_data, input logic [31:0] data);
    exp_t e;
    e.is_data = is_data;
    e.data    = data;
    return e;
  endfunction

  // Response monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (instr_rsp_o || data_rsp_o)) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", {30'b0, instr_rsp_o, data_rsp_o}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_kind", {30'b0, instr_rsp_o, data_rsp_o}, e.is_data ? 32'h1 : 32'h2);
        check("rsp_data", data_rsp_o ? data_rdata_o : instr_data_o, e.data);
      end
    end
  end

  // Waits (bounded) for a strobe; returns at the negedge of the first strobe cycle.
  task automatic wait_strobe(input string tag, output int waits);
    waits = 0;
    forever begin
      @(negedge clk);
      if (mem_rd_o || mem_wr_o) break;
      waits++;
      if (waits >= 20) break;
    end
    check({tag, "_strobe_seen"}, {31'b0, mem_rd_o | mem_wr_o}, 32'h1);
  endtask

  // Memory responder: checks the strobe for lat cycles, acks in the last, optional flush pulse.
  task automatic serve(input string tag, input int lat, input logic exp_wr,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [31:0] rdata, input int flush_cyc, output int waits);
    wait_strobe(tag, waits);
    for (int c = 1; c <= lat; c++) begin
      check({tag, "_wr"}, {31'b0, mem_wr_o}, {31'b0, exp_wr});
      check({tag, "_rd"}, {31'b0, mem_rd_o}, {31'b0, !exp_wr});
      check({tag, "_addr"}, mem_addr_o, exp_addr);
      if (exp_wr) check({tag, "_wdata"}, mem_wdata_o, exp_wdata);
      if (c == flush_cyc) instr_flush_i = 1'b1;
      if (c == lat) begin
        mem_rdata_i = rdata;
        mem_ack_i   = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      if (c == flush_cyc) begin
        instr_flush_i = 1'b0;
        instr_req_i   = 1'b0;
      end
      if (c < lat) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_rd", {31'b0, mem_rd_o}, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr_o}, 32'h0);
    check("rst_rsp", {30'b0, instr_rsp_o, data_rsp_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_bus_error", {31'b0, bus_error_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch 0x100, ack in the second strobe cycle
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    sb.push_back(mk(1'b0, 32'h00500093));
    serve("fetch1", 2, 1'b0, 32'h100, 32'h0, 32'h00500093, 0, w);
    check("fetch1_wait", w, 32'd1);
    instr_req_i = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Simultaneous fetch and load: load first, fetch strobe two cycles after data rsp
    instr_req_i = 1'b1; instr_addr_i = 32'h104;
    data_rd_i = 1'b1; data_addr_i = 32'h2000;
    sb.push_back(mk(1'b1, 32'hDEADBEEF));
    serve("prio_load", 1, 1'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 0, w);
    data_rd_i = 1'b0;
    sb.push_back(mk(1'b0, 32'h12345678));
    serve("prio_fetch", 1, 1'b0, 32'h104, 32'h0, 32'h12345678, 0, w);
    check("prio_fetch_wait", w, 32'd2);
    instr_req_i = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Store, three-cycle ack, read strobe must stay low
    data_wr_i = 1'b1; data_addr_i = 32'h3000; data_wdata_i = 32'hCAFEF00D;
    sb.push_back(mk(1'b1, 32'h0));
    serve("store", 3, 1'b1, 32'h3000, 32'hCAFEF00D, 32'h0, 0, w);
    data_wr_i = 1'b0;
    @(negedge clk);
    check("store_wr_dropped", {31'b0, mem_wr_o}, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Fetch flushed in flight: drain with no response, then a clean fetch to 0x40
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    serve("flush", 4, 1'b0, 32'h200, 32'h0, 32'hBAD0BAD0, 1, w);
    @(negedge clk);
    check("flush_idle_rd", {31'b0, mem_rd_o}, 32'h0);
    check("flush_no_rsp", {31'b0, instr_rsp_o}, 32'h0);
    @(posedge clk); #1;
    instr_req_i = 1'b1; instr_addr_i = 32'h40;
    sb.push_back(mk(1'b0, 32'h00A00113));
    serve("post_flush", 1, 1'b0, 32'h40, 32'h0, 32'h00A00113, 0, w);
    instr_req_i = 1'b0;
    repeat (3) @(posedge clk); #1;

`ifdef BUS_TIMEOUT_EN
    // Unacked fetch times out after four strobe cycles
    instr_req_i = 1'b1; instr_addr_i = 32'h500;
    sb.push_back(mk(1'b0, 32'h00000013));
    wait_strobe("tmo", w);
    begin
      int n = 0;
      while ((mem_rd_o || mem_wr_o) && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("tmo_strobe_cycles", n, 32'd4);
    end
    check("tmo_bus_error", {31'b0, bus_error_o}, 32'h1);
    instr_req_i = 1'b0;
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
    @(negedge clk);
    check("tmo_err_pulse", {31'b0, bus_error_o}, 32'h0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("tmo_late_ack_rd", {31'b0, mem_rd_o}, 32'h0);
    repeat (2) @(posedge clk); #1;
`endif

    // Reset asserted mid-load clears everything asynchronously
    data_rd_i = 1'b1; data_addr_i = 32'h600;
    wait_strobe("rst_load", w);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_rd", {31'b0, mem_rd_o}, 32'h0);
    check("arst_addr", mem_addr_o, 32'h0);
    check("arst_rdata", data_rdata_o, 32'h0);
    check("arst_instr_data", instr_data_o, 32'h0);
    data_rd_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    @(negedge clk);
    check("stale_ack_rd", {31'b0, mem_rd_o}, 32'h0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("stale_ack_no_rsp", {30'b0, instr_rsp_o, data_rsp_o}, 32'h0);
    @(posedge clk); #1;
    data_rd_i = 1'b1; data_addr_i = 32'h700;
    sb.push_back(mk(1'b1, 32'h0BADF00D));
    serve("post_rst_load", 1, 1'b0, 32'h700, 32'h0, 32'h0BADF00D, 0, w);
    data_rd_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("final_bus_error", {31'b0, bus_error_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
